// File: rtl/wb_pkg.sv
// Shared writeback-stage encodings: GRF write source and load-size codes.
// The decoder that drives GRF_write and operand_type uses the same constants.
package wb_pkg;

    localparam logic [3:0] WB_SRC_ALU  = 4'd0;
    localparam logic [3:0] WB_SRC_DM   = 4'd1;
    localparam logic [3:0] WB_SRC_LINK = 4'd2;

    localparam logic [3:0] LD_W  = 4'd0;
    localparam logic [3:0] LD_B  = 4'd1;
    localparam logic [3:0] LD_BU = 4'd2;
    localparam logic [3:0] LD_H  = 4'd3;
    localparam logic [3:0] LD_HU = 4'd4;

endpackage

// File: rtl/load_extender.sv
// Sub-word load selection and sign/zero extension of an aligned DM word.
module load_extender
    import wb_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [3:0]  load_type,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = raw >> {offset, 3'b000};
        byte_val = shifted[7:0];
        // Halves ignore offset[0]: only the two aligned halves are selectable.
        half_val = offset[1] ? raw[31:16] : raw[15:0];
        unique case (load_type)
            LD_B:    ext_data = {{24{byte_val[7]}}, byte_val};
            LD_BU:   ext_data = {24'd0, byte_val};
            LD_H:    ext_data = {{16{half_val[15]}}, half_val};
            LD_HU:   ext_data = {16'd0, half_val};
            default: ext_data = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage_grf.sv
// MIPS writeback stage: source mux, 32x32 GRF with same-cycle bypass, WB forwarding tap,
// registered retire trace and retired-write counter.
module wb_stage_grf
    import wb_pkg::*;
#(
    parameter int unsigned PC_LINK_OFFSET = 8,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_WB_IN,
    input  logic [4:0]        dst_addr_WB_IN,
    input  logic [3:0]        GRF_write_WB_IN,
    input  logic [3:0]        operand_type_WB_IN,
    input  logic [DATA_W-1:0] ALUOut_WB_IN,
    input  logic [DATA_W-1:0] DMOut_WB_IN,
    input  logic [DATA_W-1:0] PCAddr_WB_IN,
    input  logic [4:0]        RsAddr_D,
    input  logic [4:0]        RtAddr_D,
    output logic [DATA_W-1:0] Rs_D,
    output logic [DATA_W-1:0] Rt_D,
    output logic              fwd_valid_WB,
    output logic [4:0]        fwd_addr_WB,
    output logic [DATA_W-1:0] fwd_data_WB,
    output logic              retire_valid,
    output logic [DATA_W-1:0] retire_pc,
    output logic [4:0]        retire_addr,
    output logic [DATA_W-1:0] retire_data,
    output logic [DATA_W-1:0] retire_count
);

    logic              we;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_data;

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [DATA_W-1:0] grf_q [32];

    logic              retire_valid_q;
    logic [DATA_W-1:0] retire_pc_q;
    logic [4:0]        retire_addr_q;
    logic [DATA_W-1:0] retire_data_q;
    logic [DATA_W-1:0] retire_count_q;

    load_extender u_load_extender (
        .raw       (DMOut_WB_IN),
        .offset    (ALUOut_WB_IN[1:0]),
        .load_type (operand_type_WB_IN),
        .ext_data  (load_data)
    );

    always_comb begin
        we = reg_write_WB_IN && (dst_addr_WB_IN != 5'd0);
        unique case (GRF_write_WB_IN)
            WB_SRC_DM:   wb_data = load_data;
            WB_SRC_LINK: wb_data = PCAddr_WB_IN + DATA_W'(PC_LINK_OFFSET);
            default:     wb_data = ALUOut_WB_IN;
        endcase
    end

    always_comb begin
        if (RsAddr_D == 5'd0) begin
            Rs_D = '0;
        end else if (we && (RsAddr_D == dst_addr_WB_IN)) begin
            Rs_D = wb_data;
        end else begin
            Rs_D = grf_q[RsAddr_D];
        end
        if (RtAddr_D == 5'd0) begin
            Rt_D = '0;
        end else if (we && (RtAddr_D == dst_addr_WB_IN)) begin
            Rt_D = wb_data;
        end else begin
            Rt_D = grf_q[RtAddr_D];
        end
    end

    always_comb begin
        fwd_valid_WB = we;
        fwd_addr_WB  = we ? dst_addr_WB_IN : 5'd0;
        fwd_data_WB  = we ? wb_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_q[i] <= '0;
            end
        end else if (we) begin
            grf_q[dst_addr_WB_IN] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_addr_q  <= 5'd0;
            retire_data_q  <= '0;
            retire_count_q <= '0;
        end else if (we) begin
            retire_valid_q <= 1'b1;
            retire_pc_q    <= PCAddr_WB_IN;
            retire_addr_q  <= dst_addr_WB_IN;
            retire_data_q  <= wb_data;
            retire_count_q <= retire_count_q + 1'b1;
        end else begin
            retire_valid_q <= 1'b0;
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
    assign retire_addr  = retire_addr_q;
    assign retire_data  = retire_data_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_stage_grf.sv
// Randomized scoreboard bench for wb_stage_grf against a behavioural register-file model.
module tb_wb_stage_grf;

    logic        clk;
    logic        reset;
    logic        reg_write_WB_IN;
    logic [4:0]  dst_addr_WB_IN;
    logic [3:0]  GRF_write_WB_IN;
    logic [3:0]  operand_type_WB_IN;
    logic [31:0] ALUOut_WB_IN;
    logic [31:0] DMOut_WB_IN;
    logic [31:0] PCAddr_WB_IN;
    logic [4:0]  RsAddr_D;
    logic [4:0]  RtAddr_D;
    logic [31:0] Rs_D;
    logic [31:0] Rt_D;
    logic        fwd_valid_WB;
    logic [4:0]  fwd_addr_WB;
    logic [31:0] fwd_data_WB;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [4:0]  retire_addr;
    logic [31:0] retire_data;
    logic [31:0] retire_count;

    wb_stage_grf #(
        .PC_LINK_OFFSET (8),
        .DATA_W         (32)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .reg_write_WB_IN    (reg_write_WB_IN),
        .dst_addr_WB_IN     (dst_addr_WB_IN),
        .GRF_write_WB_IN    (GRF_write_WB_IN),
        .operand_type_WB_IN (operand_type_WB_IN),
        .ALUOut_WB_IN       (ALUOut_WB_IN),
        .DMOut_WB_IN        (DMOut_WB_IN),
        .PCAddr_WB_IN       (PCAddr_WB_IN),
        .RsAddr_D           (RsAddr_D),
        .RtAddr_D           (RtAddr_D),
        .Rs_D               (Rs_D),
        .Rt_D               (Rt_D),
        .fwd_valid_WB       (fwd_valid_WB),
        .fwd_addr_WB        (fwd_addr_WB),
        .fwd_data_WB        (fwd_data_WB),
        .retire_valid       (retire_valid),
        .retire_pc          (retire_pc),
        .retire_addr        (retire_addr),
        .retire_data        (retire_data),
        .retire_count       (retire_count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] count;
    } trace_t;

    trace_t      sb_q[$];
    trace_t      m_tr;
    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;
    bit          mon_en;
    int          n_cmp;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference writeback value, computed from byte/half arithmetic on the raw word.
    function automatic logic [31:0] model_wb(input logic [3:0] src, input logic [3:0] ty,
                                             input logic [31:0] alu, input logic [31:0] dm,
                                             input logic [31:0] pc);
        int unsigned off;
        logic [31:0] v;
        if (src == 4'd2) return pc + 32'd8;
        if (src != 4'd1) return alu;
        off = alu % 4;
        case (ty)
            4'd1, 4'd2: begin
                v = (dm / (32'd1 << (8 * off))) % 256;
                if (ty == 4'd1 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            4'd3, 4'd4: begin
                v = (off >= 2) ? dm / 65536 : dm % 65536;
                if (ty == 4'd3 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = dm;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                               input logic [4:0] dst, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (we && a == dst) return v;
        return m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_cnt = 32'd0;
        m_tr = '{valid: 1'b0, pc: 32'd0, addr: 5'd0, data: 32'd0, count: 32'd0};
    endtask

    task automatic drive(input bit rw, input logic [4:0] dst, input logic [3:0] src,
                         input logic [3:0] ty, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
        bit          we;
        logic [31:0] v;
        @(negedge clk);
        reg_write_WB_IN    = rw;
        dst_addr_WB_IN     = dst;
        GRF_write_WB_IN    = src;
        operand_type_WB_IN = ty;
        ALUOut_WB_IN       = alu;
        DMOut_WB_IN        = dm;
        PCAddr_WB_IN       = pc;
        RsAddr_D           = rs;
        RtAddr_D           = rt;
        #1;
        we = rw && (dst != 5'd0);
        v  = model_wb(src, ty, alu, dm, pc);
        check("fwd_valid", {31'd0, fwd_valid_WB}, {31'd0, we});
        check("fwd_addr", {27'd0, fwd_addr_WB}, we ? {27'd0, dst} : 32'd0);
        check("fwd_data", fwd_data_WB, we ? v : 32'd0);
        check("rs_read", Rs_D, model_read(rs, we, dst, v));
        check("rt_read", Rt_D, model_read(rt, we, dst, v));
        if (we) begin
            m_rf[dst] = v;
            m_cnt     = m_cnt + 32'd1;
            m_tr      = '{valid: 1'b1, pc: pc, addr: dst, data: v, count: m_cnt};
        end else begin
            m_tr.valid = 1'b0;
            m_tr.count = m_cnt;
        end
        sb_q.push_back(m_tr);
        mon_en = 1'b1;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b0, 5'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, rs, rt);
    endtask

    // Monitor: every edge after stimulus, pop the expected trace and compare.
    always @(posedge clk) begin
        trace_t e;
        #1;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("retire_valid", {31'd0, retire_valid}, {31'd0, e.valid});
                check("retire_pc", retire_pc, e.pc);
                check("retire_addr", {27'd0, retire_addr}, {27'd0, e.addr});
                check("retire_data", retire_data, e.data);
                check("retire_count", retire_count, e.count);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        model_reset();
        reset              = 1'b0;
        reg_write_WB_IN    = 1'b0;
        dst_addr_WB_IN     = 5'd0;
        GRF_write_WB_IN    = 4'd0;
        operand_type_WB_IN = 4'd0;
        ALUOut_WB_IN       = 32'd0;
        DMOut_WB_IN        = 32'd0;
        PCAddr_WB_IN       = 32'd0;
        RsAddr_D           = 5'd0;
        RtAddr_D           = 5'd0;
        #22;
        reset = 1'b1;

        // Reset state.
        idle(5'd5, 5'd0);
        check("rst_rs5", Rs_D, 32'd0);
        check("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("rst_retire_count", retire_count, 32'd0);

        // ALU write with same-cycle bypass, then registered value and trace.
        drive(1'b1, 5'd8, 4'd0, 4'd0, 32'h1234_5678, 32'd0, 32'h0000_1000, 5'd8, 5'd8);
        check("alu_bypass", Rs_D, 32'h1234_5678);
        idle(5'd8, 5'd0);
        check("alu_stored", Rs_D, 32'h1234_5678);
        check("alu_retire_addr", {27'd0, retire_addr}, 32'd8);
        check("alu_retire_count", retire_count, 32'd1);

        // Sub-word loads.
        drive(1'b1, 5'd10, 4'd1, 4'd1, 32'h0000_0013, 32'h80FF_7F01, 32'h10, 5'd10, 5'd0);
        check("lb", fwd_data_WB, 32'hFFFF_FF80);
        drive(1'b1, 5'd11, 4'd1, 4'd2, 32'h0000_0013, 32'h80FF_7F01, 32'h14, 5'd0, 5'd11);
        check("lbu", fwd_data_WB, 32'h0000_0080);
        drive(1'b1, 5'd12, 4'd1, 4'd3, 32'h0000_0012, 32'h80FF_7F01, 32'h18, 5'd10, 5'd12);
        check("lh", fwd_data_WB, 32'hFFFF_80FF);
        drive(1'b1, 5'd13, 4'd1, 4'd4, 32'h0000_0012, 32'h80FF_7F01, 32'h1C, 5'd11, 5'd13);
        check("lhu", fwd_data_WB, 32'h0000_80FF);

        // Link write and a dropped write to $0.
        drive(1'b1, 5'd31, 4'd2, 4'd0, 32'hDEAD_BEEF, 32'd0, 32'h0000_3004, 5'd31, 5'd31);
        check("link", Rt_D, 32'h0000_300C);
        drive(1'b1, 5'd0, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'd0, 32'h40, 5'd0, 5'd0);
        check("zero_fwd_valid", {31'd0, fwd_valid_WB}, 32'd0);
        check("zero_read", Rs_D, 32'd0);
        idle(5'd0, 5'd31);
        check("zero_no_trace", {31'd0, retire_valid}, 32'd0);

        // Counter wrap from a preloaded all-ones value.
        @(posedge clk);
        #2;
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 5'd3, 4'd0, 4'd0, 32'h0000_00AA, 32'd0, 32'h50, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        check("count_wrap", retire_count, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            logic [4:0] rs;
            logic [4:0] rt;
            d  = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 9) < 7, d, 4'($urandom_range(0, 5)),
                  4'($urandom_range(0, 6)), $urandom, $urandom, $urandom, rs, rt);
        end

        // Asynchronous reset between edges, with a write pending in WB.
        drive(1'b1, 5'd9, 4'd0, 4'd0, 32'hCAFE_0009, 32'd0, 32'h60, 5'd9, 5'd0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        @(negedge clk);
        ALUOut_WB_IN = 32'h5555_5555;
        #2;
        reset = 1'b0;
        #1;
        check("async_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("async_retire_count", retire_count, 32'd0);
        @(posedge clk);
        #2;
        reg_write_WB_IN = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        model_reset();
        idle(5'd9, 5'd8);
        check("post_reset_r9", Rs_D, 32'd0);
        drive(1'b1, 5'd9, 4'd0, 4'd0, 32'h0000_0777, 32'd0, 32'h70, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        check("post_reset_count", retire_count, 32'd1);

        @(posedge clk);
        #3;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
